// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_sequencer
// Brief    : Drives a Wishbone SPI master core for an I2C slave bridge.
//            Consumes framed command bytes and programs, polls and reads
//            the SPI core for each byte. Every MISO byte is returned as a
//            response stream. Owns cs_n so a whole frame (or a chain of
//            frames) forms one uninterrupted SPI transaction.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
  parameter logic [7:0] SPCR_INIT   = 8'h50,
  parameter logic [7:0] SPER_INIT   = 8'h00,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic       i2c_wb_clk_i,
  input  logic       i2c_wb_rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i,
  output logic       cs_n,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] S_CFG0 = 4'd0;
  localparam logic [3:0] S_CFG1 = 4'd1;
  localparam logic [3:0] S_IDLE = 4'd2;
  localparam logic [3:0] S_GETB = 4'd3;
  localparam logic [3:0] S_WRDR = 4'd4;
  localparam logic [3:0] S_POLL = 4'd5;
  localparam logic [3:0] S_CLRF = 4'd6;
  localparam logic [3:0] S_RDDR = 4'd7;
  localparam logic [3:0] S_PUSH = 4'd8;
  localparam logic [3:0] S_ENDF = 4'd9;

  localparam logic [1:0] A_SPCR = 2'd0;
  localparam logic [1:0] A_SPSR = 2'd1;
  localparam logic [1:0] A_SPDR = 2'd2;
  localparam logic [1:0] A_SPER = 2'd3;

  // Last timer value before giving up; strobe stays up ACK_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [3:0] state_q, state_d;
  logic       stb_q,   stb_d;
  logic [1:0] adr_q,   adr_d;
  logic [7:0] dat_q,   dat_d;
  logic       we_q,    we_d;
  logic [7:0] tmr_q,   tmr_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       hold_q,  hold_d;
  logic [7:0] txd_q,   txd_d;
  logic       cs_n_q,  cs_n_d;
  logic       err_q,   err_d;

  logic bus_state;
  logic ack_ev;
  logic tmo_ev;

  // States that own a Wishbone access; a strobe is (re)issued whenever idle.
  always_comb begin
    bus_state = (state_q == S_CFG0) || (state_q == S_CFG1) || (state_q == S_WRDR) ||
                (state_q == S_POLL) || (state_q == S_CLRF) || (state_q == S_RDDR);
    ack_ev    = stb_q & wb_ack_i;
    tmo_ev    = stb_q & ~wb_ack_i & (tmr_q == TMO_LAST);
  end

  // Next-state logic: issue access, retire on ack, abort on timeout, frame flow.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    txd_d   = txd_q;
    cs_n_d  = cs_n_q;
    err_d   = err_q;

    if (bus_state && !stb_q) begin
      stb_d = 1'b1;
      tmr_d = 8'd0;
      case (state_q)
        S_CFG0:  begin adr_d = A_SPCR; dat_d = SPCR_INIT; we_d = 1'b1; end
        S_CFG1:  begin adr_d = A_SPER; dat_d = SPER_INIT; we_d = 1'b1; end
        S_WRDR:  begin adr_d = A_SPDR; we_d = 1'b1; end
        S_POLL:  begin adr_d = A_SPSR; we_d = 1'b0; end
        S_CLRF:  begin adr_d = A_SPSR; dat_d = 8'h80; we_d = 1'b1; end
        S_RDDR:  begin adr_d = A_SPDR; we_d = 1'b0; end
        default: ;
      endcase
    end else if (tmo_ev) begin
      // Unresponsive core: release the slave and park, remembering the fault.
      stb_d   = 1'b0;
      err_d   = 1'b1;
      cs_n_d  = 1'b1;
      state_d = S_IDLE;
    end else if (ack_ev) begin
      stb_d = 1'b0;
      case (state_q)
        S_CFG0:  state_d = S_CFG1;
        S_CFG1:  state_d = S_IDLE;
        S_WRDR:  state_d = S_POLL;
        S_POLL:  if (wb_dat_i[7]) state_d = S_CLRF;
        S_CLRF:  state_d = S_RDDR;
        S_RDDR:  begin txd_d = wb_dat_i; state_d = S_PUSH; end
        default: ;
      endcase
    end else if (stb_q) begin
      tmr_d = tmr_q + 8'd1;
    end else begin
      case (state_q)
        S_IDLE: if (rx_valid) begin
          cnt_d   = rx_data[3:0];
          hold_d  = rx_data[7];
          state_d = S_GETB;
        end
        S_GETB: if (rx_valid) begin
          // Start the SPDR write right away to save a cycle per byte.
          dat_d   = rx_data;
          adr_d   = A_SPDR;
          we_d    = 1'b1;
          stb_d   = 1'b1;
          tmr_d   = 8'd0;
          cs_n_d  = 1'b0;
          state_d = S_WRDR;
        end
        S_PUSH: if (tx_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = S_ENDF;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = S_GETB;
          end
        end
        S_ENDF: begin
          cs_n_d  = ~hold_q;
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q <= S_CFG0;
      stb_q   <= 1'b0;
      adr_q   <= 2'd0;
      dat_q   <= 8'd0;
      we_q    <= 1'b0;
      tmr_q   <= 8'd0;
      cnt_q   <= 4'd0;
      hold_q  <= 1'b0;
      txd_q   <= 8'd0;
      cs_n_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      txd_q   <= txd_d;
      cs_n_q  <= cs_n_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_GETB);
  assign tx_valid = (state_q == S_PUSH);
  assign tx_data  = txd_q;
  assign busy     = (state_q != S_IDLE);
  assign wb_cyc_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign cs_n     = cs_n_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_sequencer
// Brief    : Bench for spi_xfer_sequencer. A Wishbone SPI-core model echoes
//            ~MOSI; expected responses are queued when a frame is sent and
//            popped by an independent tx monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_we_o, wb_cyc_o, wb_stb_o;
  logic       wb_ack_i = 1'b0;
  logic       cs_n, busy, err;

  always #5 clk = ~clk;

  spi_xfer_sequencer dut (
    .i2c_wb_clk_i (clk),
    .i2c_wb_rst_i (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .cs_n         (cs_n),
    .busy         (busy),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected MISO bytes, in order.
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  // SPI-core model knobs and state.
  int         ack_wait   = 0;
  int         poll_zeros = 0;
  bit         no_ack     = 1'b0;
  int         tx_mode    = 0;   // 0 always ready, 1 random, 2 held low
  logic [7:0] mosi       = 8'h00;
  int         spif_cd    = 0;
  int         wcnt       = 0;
  int         stb_cnt    = 0;
  int         poll_cnt   = 0;
  int         clrf_cnt   = 0;
  logic [9:0] cfg_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: SPI core whose slave echoes the inverted MOSI byte.
  always @(negedge clk) begin
    check("cyc_equals_stb", wb_cyc_o, wb_stb_o);
    if (wb_stb_o) stb_cnt++;
    if (wb_stb_o && !no_ack && !wb_ack_i) begin
      if (wcnt >= ack_wait) begin
        wb_ack_i = 1'b1;
        wcnt     = 0;
        if (wb_adr_o == 2'd1 || wb_adr_o == 2'd2)
          check("cs_low_during_byte", cs_n, 1'b0);
        if (wb_we_o) begin
          case (wb_adr_o)
            2'd0, 2'd3: cfg_log.push_back({wb_adr_o, wb_dat_o});
            2'd2: begin mosi = wb_dat_o; spif_cd = poll_zeros; end
            default: begin clrf_cnt++; check("spsr_clear_value", wb_dat_o, 8'h80); end
          endcase
        end else begin
          case (wb_adr_o)
            2'd1: begin
              poll_cnt++;
              if (spif_cd > 0) begin wb_dat_i = 8'h00; spif_cd--; end
              else wb_dat_i = 8'h80;
            end
            2'd2:    wb_dat_i = ~mosi;
            default: wb_dat_i = 8'h00;
          endcase
        end
      end else begin
        wb_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      if (!wb_stb_o) wcnt = 0;
    end
  end

  // tx sink and monitor: pops the scoreboard on each accepted response.
  always @(negedge clk) begin
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 2) != 0);
      default: tx_ready = 1'b0;
    endcase
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %02h expected none", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte", tx_data, exp_b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout: got rx_ready=0 expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || exp_q.size() != 0) && t < 20000);
    if (t >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy=%0d pending=%0d expected 0 0", name, busy, exp_q.size());
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] d[16], input bit expect_resp);
    logic [7:0] e;
    for (int i = 0; i <= int'(hdr[3:0]); i++) begin
      e = ~d[i];
      if (expect_resp) exp_q.push_back(e);
    end
    send_byte(hdr);
    for (int i = 0; i <= int'(hdr[3:0]); i++) send_byte(d[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[16];
    logic [7:0] hdr;
    logic [7:0] txd;
    logic       exp_cs;
    int         stall_bad;
    int         t;

    for (int i = 0; i < 16; i++) d[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rx_ready, tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, cs_n, busy, err},
          {1'b0, 1'b0, 8'h00, 3'b000, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0});
    rst = 1'b0;

    // Configuration writes.
    wait_idle("cfg");
    check("cfg_write_count", cfg_log.size(), 2);
    check("cfg_spcr", (cfg_log.size() > 0) ? cfg_log[0] : 10'h3ff, {2'd0, 8'h50});
    check("cfg_sper", (cfg_log.size() > 1) ? cfg_log[1] : 10'h3ff, {2'd3, 8'h00});
    check("idle_busy_rxready", {busy, rx_ready}, 2'b01);

    // Two-byte frame, echo of inverted MOSI.
    d[0] = 8'hA5; d[1] = 8'h3C;
    run_frame(8'h01, d, 1'b1);
    wait_idle("two_byte");
    check("cs_high_after_frame", cs_n, 1'b1);

    // SPIF appears on the fourth status read.
    poll_zeros = 3; poll_cnt = 0; clrf_cnt = 0;
    d[0] = 8'h96;
    run_frame(8'h00, d, 1'b1);
    wait_idle("poll");
    poll_zeros = 0;
    check("poll_reads", poll_cnt, 4);
    check("spif_clears", clrf_cnt, 1);

    // Chained frames keep cs_n low in between.
    d[0] = 8'h11;
    run_frame(8'h80, d, 1'b1);
    wait_idle("chain1");
    check("cs_held_between_frames", cs_n, 1'b0);
    d[0] = 8'h22;
    run_frame(8'h00, d, 1'b1);
    wait_idle("chain2");
    check("cs_high_after_chain", cs_n, 1'b1);

    // tx backpressure: outputs frozen, core untouched.
    tx_mode = 2;
    d[0] = 8'h77;
    run_frame(8'h00, d, 1'b1);
    t = 0;
    while (!tx_valid && t < 2000) begin @(negedge clk); t++; end
    check("stall_reached_push", tx_valid, 1'b1);
    txd = tx_data;
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== txd || wb_stb_o || rx_ready) stall_bad++;
    end
    check("stall_stable", stall_bad, 0);
    tx_mode = 0;
    wait_idle("stall");

    // Ack timeout on the SPDR write, even with hold requested.
    no_ack = 1'b1;
    stb_cnt = 0;
    d[0] = 8'h55;
    run_frame(8'h80, d, 1'b0);
    wait_idle("timeout");
    no_ack = 1'b0;
    check("timeout_strobe_cycles", stb_cnt, 255);
    check("timeout_err_cs_busy", {err, cs_n, busy}, 3'b110);

    // Random frames after the fault; err must remain set.
    tx_mode = 1;
    for (int f = 0; f < 25; f++) begin
      hdr[7]   = (f != 24) && ($urandom_range(0, 1) == 1);
      hdr[6:4] = 3'($urandom);
      hdr[3:0] = 4'($urandom_range(0, 3));
      ack_wait   = $urandom_range(0, 2);
      poll_zeros = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      run_frame(hdr, d, 1'b1);
      wait_idle("rand");
      exp_cs = ~hdr[7];
      check("rand_cs_after_frame", cs_n, exp_cs);
      check("rand_err_sticky", err, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
